// File: rtl/audio_envelope_pwm.sv
// audio_envelope_pwm: ADSR envelope and master volume applied to a square tone, driven out through a PWM DAC.
// Ports: clk, rst_n (async active-low); tone_in (async square tone), note_on (note strobe), silent (rest level),
// volume (master volume); AUD_PWM (PWM audio), AUD_SD (amp enable), env_level (envelope), busy (not IDLE).
// Optional: define AUD_SHUTDOWN_EN to drive AUD_SD from the FSM; otherwise AUD_SD is tied high.
module audio_envelope_pwm #(
  parameter int PWM_BITS     = 8,
  parameter int ENV_STEP_DIV = 100000,
  parameter int ATTACK_STEP  = 32,
  parameter int DECAY_STEP   = 4,
  parameter int SUSTAIN_LVL  = 128,
  parameter int RELEASE_STEP = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tone_in,
  input  logic                note_on,
  input  logic                silent,
  input  logic [PWM_BITS-1:0] volume,
  output logic                AUD_PWM,
  output logic                AUD_SD,
  output logic [PWM_BITS-1:0] env_level,
  output logic                busy
);
  localparam logic [2:0] IDLE = 3'd0, ATTACK = 3'd1, DECAY = 3'd2, SUSTAIN = 3'd3, RELEASE = 3'd4;
  localparam int PW = ENV_STEP_DIV > 1 ? $clog2(ENV_STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;
  logic [PW-1:0] pre;
  logic tick, active, tone_s1, tone_s2;
  logic [2:0] state, state_nx;
  logic [PWM_BITS:0] up;
  logic [PWM_BITS-1:0] a_lvl, d_lvl, r_lvl, lvl_nx, amp, sample, pwm_cnt, sample_lat;
  logic [2*PWM_BITS-1:0] prod;
  assign tick = pre == PW'(ENV_STEP_DIV - 1);
  assign active = state == ATTACK || state == DECAY || state == SUSTAIN;
  // Attack sum is one bit wider so the overflow past full scale can be clamped.
  assign up = {1'b0, env_level} + (PWM_BITS+1)'(ATTACK_STEP);
  assign a_lvl = up > {1'b0, MAX} ? MAX : up[PWM_BITS-1:0];
  assign d_lvl = {1'b0, env_level} <= (PWM_BITS+1)'(SUSTAIN_LVL + DECAY_STEP) ? PWM_BITS'(SUSTAIN_LVL)
                                                                               : env_level - PWM_BITS'(DECAY_STEP);
  assign r_lvl = env_level <= PWM_BITS'(RELEASE_STEP) ? '0 : env_level - PWM_BITS'(RELEASE_STEP);
  always_comb begin
    lvl_nx = !tick             ? env_level :
             state == ATTACK   ? a_lvl :
             state == DECAY    ? d_lvl :
             state == RELEASE  ? r_lvl :
             state == SUSTAIN  ? env_level : '0;
    // silent suppresses a coincident note_on; otherwise note_on retriggers from any state at the current level.
    state_nx = silent && active                                   ? RELEASE :
               note_on && !silent                                 ? ATTACK :
               !tick                                              ? state :
               state == ATTACK && a_lvl == MAX                    ? DECAY :
               state == DECAY && d_lvl == PWM_BITS'(SUSTAIN_LVL)  ? SUSTAIN :
               state == RELEASE && r_lvl == '0                    ? IDLE : state;
  end
  assign prod = {{PWM_BITS{1'b0}}, env_level} * {{PWM_BITS{1'b0}}, volume};
  assign amp = prod[2*PWM_BITS-1:PWM_BITS];
  assign sample = tone_s2 ? amp : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre        <= '0;
      state      <= IDLE;
      env_level  <= '0;
      busy       <= 1'b0;
      tone_s1    <= 1'b0;
      tone_s2    <= 1'b0;
      pwm_cnt    <= '0;
      sample_lat <= '0;
      AUD_PWM    <= 1'b0;
    end else begin
      pre        <= tick ? '0 : pre + PW'(1);
      state      <= state_nx;
      env_level  <= lvl_nx;
      busy       <= state_nx != IDLE;
      tone_s1    <= tone_in;
      tone_s2    <= tone_s1;
      pwm_cnt    <= pwm_cnt + PWM_BITS'(1);
      // Sample only at the frame boundary so every PWM frame has a single stable duty.
      sample_lat <= pwm_cnt == MAX ? sample : sample_lat;
      AUD_PWM    <= pwm_cnt < sample_lat;
    end
  end
`ifdef AUD_SHUTDOWN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) AUD_SD <= 1'b0;
    else AUD_SD <= state != IDLE;
  end
`else
  assign AUD_SD = 1'b1;
`endif
endmodule

// File: tb/tb_audio_envelope_pwm.sv
// tb_audio_envelope_pwm: randomized and directed check of audio_envelope_pwm against a behavioural model.
module tb_audio_envelope_pwm;
  localparam int DIV = 4, AS = 64, DS = 16, SUS = 128, RS = 32, MAXV = 255;
`ifdef AUD_SHUTDOWN_EN
  localparam int SD_RST = 0;
`else
  localparam int SD_RST = 1;
`endif
  typedef enum int {P_IDLE, P_ATK, P_DEC, P_SUS, P_REL} phase_t;
  logic clk = 1'b0;
  logic rst_n, tone_in, note_on, silent, AUD_PWM, AUD_SD, busy;
  logic [7:0] volume, env_level;
  int tests = 0, fails = 0;
  bit cmp_en = 1'b0;
  int seq[$];
  int exp_q[$];
  phase_t m_ph;
  int m_lvl, m_pre, m_s1, m_s2, m_cnt, m_lat, m_pwm, m_sd;

  audio_envelope_pwm #(.PWM_BITS(8), .ENV_STEP_DIV(DIV), .ATTACK_STEP(AS), .DECAY_STEP(DS),
                       .SUSTAIN_LVL(SUS), .RELEASE_STEP(RS)) dut (
    .clk(clk), .rst_n(rst_n), .tone_in(tone_in), .note_on(note_on), .silent(silent), .volume(volume),
    .AUD_PWM(AUD_PWM), .AUD_SD(AUD_SD), .env_level(env_level), .busy(busy));

  always #5 clk = ~clk;

  function automatic int nlvl(phase_t p, int l);
    case (p)
      P_ATK:   return (l + AS > MAXV) ? MAXV : l + AS;
      P_DEC:   return (l - DS < SUS) ? SUS : l - DS;
      P_REL:   return (l - RS < 0) ? 0 : l - RS;
      P_SUS:   return l;
      default: return 0;
    endcase
  endfunction

  function automatic phase_t nph(phase_t p, int l, bit tk, bit no, bit si);
    int n;
    if (si && (p == P_ATK || p == P_DEC || p == P_SUS)) return P_REL;
    if (no && !si) return P_ATK;
    if (!tk) return p;
    n = nlvl(p, l);
    if (p == P_ATK && n == MAXV) return P_DEC;
    if (p == P_DEC && n == SUS) return P_SUS;
    if (p == P_REL && n == 0) return P_IDLE;
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= P_IDLE; m_lvl <= 0; m_pre <= 0; m_s1 <= 0; m_s2 <= 0;
      m_cnt <= 0; m_lat <= 0; m_pwm <= 0; m_sd <= SD_RST;
    end else begin
      m_pre <= (m_pre + 1) % DIV;
      m_lvl <= (m_pre == DIV - 1) ? nlvl(m_ph, m_lvl) : m_lvl;
      m_ph  <= nph(m_ph, m_lvl, m_pre == DIV - 1, note_on, silent);
      m_s1  <= int'(tone_in);
      m_s2  <= m_s1;
      m_cnt <= (m_cnt + 1) % 256;
      if (m_cnt == 255) m_lat <= m_s2 != 0 ? (m_lvl * int'(volume)) / 256 : 0;
      m_pwm <= int'(m_cnt < m_lat);
`ifdef AUD_SHUTDOWN_EN
      m_sd  <= int'(m_ph != P_IDLE);
`else
      m_sd  <= 1;
`endif
    end
  end

  task automatic chk(string name, int act, int expv);
    tests++;
    if (act != expv) begin
      fails++;
      if (fails < 40) $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("env_level", int'(env_level), m_lvl);
      chk("busy", int'(busy), int'(m_ph != P_IDLE));
      chk("AUD_PWM", int'(AUD_PWM), m_pwm);
      chk("AUD_SD", int'(AUD_SD), m_sd);
    end
  end

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic capture(int n);
    int last;
    seq.delete();
    last = int'(env_level);
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (int'(env_level) != last) begin
        last = int'(env_level);
        seq.push_back(last);
      end
    end
  endtask

  task automatic check_seq(string name);
    chk({name, "_len"}, seq.size(), exp_q.size());
    for (int i = 0; i < seq.size() && i < exp_q.size(); i++) chk(name, seq[i], exp_q[i]);
  endtask

  task automatic count_high(int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin cyc(1); c += int'(AUD_PWM); end
  endtask

  task automatic next_change(string name, int expv);
    int last, got;
    last = int'(env_level);
    got = -1;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (int'(env_level) != last) begin got = int'(env_level); break; end
    end
    chk(name, got, expv);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, found;
    rst_n = 1'b0; note_on = 1'b0; silent = 1'b0; tone_in = 1'b1; volume = 8'd255;
    cyc(3);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    chk("reset_env", int'(env_level), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pwm", int'(AUD_PWM), 0);
    chk("reset_sd", int'(AUD_SD), SD_RST);
    // attack then decay into sustain
    note_on = 1'b1; cyc(1); note_on = 1'b0;
    chk("busy_after_note", int'(busy), 1);
    capture(80);
    exp_q = '{64, 128, 192, 255, 239, 223, 207, 191, 175, 159, 143, 128};
    check_seq("adsr_seq");
    chk("busy_sustain", int'(busy), 1);
    // PWM duty at sustain level 128
    cyc(600); count_high(256, c); chk("pwm_127", c, 127);
    tone_in = 1'b0; cyc(600); count_high(256, c); chk("pwm_tone0", c, 0);
    tone_in = 1'b1; volume = 8'd0; cyc(600); count_high(256, c); chk("pwm_vol0", c, 0);
    volume = 8'd255;
    // note_on together with silent: release wins
    silent = 1'b1; note_on = 1'b1; cyc(1); note_on = 1'b0;
    chk("busy_release", int'(busy), 1);
    capture(40);
    exp_q = '{96, 64, 32, 0};
    check_seq("release_seq");
    chk("busy_idle", int'(busy), 0);
    // retrigger from release at level 64
    silent = 1'b0; note_on = 1'b1; cyc(1); note_on = 1'b0;
    cyc(80);
    silent = 1'b1;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (env_level == 8'd64) begin found = 1; break; end
    end
    chk("found_64", found, 1);
    silent = 1'b0; note_on = 1'b1; cyc(1); note_on = 1'b0;
    next_change("retrigger_128", 128);
    note_on = 1'b1; cyc(1); note_on = 1'b0;
    next_change("attack_retrig_192", 192);
    // async reset mid-attack
    cyc(1); #3; rst_n = 1'b0; #1;
    chk("arst_env", int'(env_level), 0);
    chk("arst_pwm", int'(AUD_PWM), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_sd", int'(AUD_SD), SD_RST);
    @(posedge clk); #1; rst_n = 1'b1;
    cyc(20);
    chk("idle_after_rst_env", int'(env_level), 0);
    chk("idle_after_rst_busy", int'(busy), 0);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(1);
      note_on = $urandom_range(0, 999) < 25;
      if ($urandom_range(0, 59) == 0) silent = ~silent;
      if ($urandom_range(0, 5) == 0) tone_in = ~tone_in;
      if ($urandom_range(0, 299) == 0) volume = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1999) == 0) begin
        #3; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
      end
    end
    note_on = 1'b0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
